seg_scan: RTL
=============

# seg_scan

Time-multiplexing scanner for the 8-digit seven-segment display, downstream of the digit-pattern generator. It takes eight active-low segment patterns in parallel and drives a single shared active-low segment bus plus eight active-low digit enables. Each digit is shown for a fixed dwell, then the display is blanked for a short gap to suppress ghosting. All eight patterns are snapshotted once per frame so a displayed frame is never torn.

## Interface
- DWELL, 50: clocks each digit is driven; must be ≥ 1.
- BLANK, 2: clocks of full blanking after each digit; may be 0.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset; synchronous and active-high.
- i_en  input  1  scan enable; low forces display blank and idle.
- i_seg0..i_seg7  input  8 each  active-low segment patterns for digits 0..7 (bit 7 = segment a … bit 0 = dp, bit order passed through untouched).
- o_seg  output  8  active-low shared segment bus.
- o_an  output  8  active-low digit enables; bit k selects digit k; at most one bit low.
- o_frame  output  1  one-cycle pulse marking each snapshot (LOAD cycle).

## Operation
- States: IDLE, LOAD, SHOW, GAP. Registers: state, digit index idx (3 bits), dwell/gap counter cnt (32 bits), snapshot snap[0..7] (8 bits each).
- Outputs are registered and consistent with the current state: in SHOW, o_an = ~(8'b1 << idx) and o_seg = snap[idx]; in every other state o_an = 8'hFF and o_seg = 8'hFF.
- o_frame = 1 exactly in LOAD cycles, else 0.
- IDLE: if i_en = 1, go to LOAD; otherwise stay.
- LOAD (1 cycle): snap[k] <= i_segk for all k; idx <= 0; cnt <= 0; go to SHOW.
- SHOW: cnt increments each cycle. When cnt = DWELL-1: cnt <= 0; if BLANK > 0 go to GAP. If BLANK = 0 and idx = 7, go to LOAD. If BLANK = 0 and idx < 7, idx <= idx+1 and stay in SHOW.
- GAP: cnt increments each cycle. When cnt = BLANK-1: cnt <= 0; if idx = 7 go to LOAD, else idx <= idx+1 and go to SHOW.
- i_en = 0 sampled in any state: next state IDLE, outputs blank from the next cycle; idx and cnt cleared. A frame interrupted this way is discarded; re-enable always restarts with LOAD at digit 0.
- Inputs i_seg* are sampled only in LOAD; changes at any other time do not affect the current frame.
- idx never wraps silently: the 7→0 transition happens only through LOAD.

## Timing
- Reset values: state IDLE, idx 0, cnt 0, snap all 8'hFF, o_seg 8'hFF, o_an 8'hFF, o_frame 0.
- rst takes precedence over i_en. rst asserted mid-frame returns everything to reset values on that edge.
- With i_en held high: the first edge with rst = 0 enters LOAD; the next edge enters SHOW for digit 0.
- Latency from i_en sampled high in IDLE to o_an[0] low: 2 cycles.
- Per digit: DWELL cycles in SHOW followed by BLANK cycles in GAP.
- Frame period (LOAD to LOAD): 1 + 8·(DWELL+BLANK) cycles. During LOAD and GAP the outputs are blank, so no two anodes are ever low in the same cycle and there is no anode-to-anode overlap.
- Disable latency: i_en sampled low on edge N → blank outputs from edge N.

## Test plan
- Reset/idle: hold rst for 3 cycles, then i_en = 0 for 20 cycles → o_seg = 8'hFF, o_an = 8'hFF, o_frame = 0 throughout.
- Basic scan (DWELL = 4, BLANK = 1, i_segk = 8'h10+k, i_en = 1): o_frame pulses every 41 cycles. o_an steps FE, FD, FB, … 7F, each for 4 cycles, separated by 1 blank cycle. o_seg equals 8'h10..8'h17 in step with o_an.
- Snapshot coherence: change all i_seg* to 8'hAA in the middle of digit 3 → digits 3..7 of the current frame still show the old values; 8'hAA appears on every digit only after the next o_frame.
- BLANK = 0 (DWELL = 2): there are no blank cycles between digits, o_an changes directly FE→FD, and the frame period is 17 cycles.
- Disable mid-frame: drop i_en during digit 5 SHOW → outputs are 8'hFF from the next cycle. Re-raising i_en gives LOAD, then digit 0, 2 cycles later.
- Reset mid-frame: assert rst during GAP after digit 2 → all outputs take reset values on that edge. After release with i_en = 1, scanning restarts at digit 0.

Source files
------------

// File: rtl/seg_scan.sv
// Time-multiplexed scanner for an 8-digit active-low seven-segment display.
// Each frame snapshots all patterns, then shows every digit for DWELL clocks with BLANK-clock gaps between digits.

module seg_snap_cell (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= 8'hFF;
    else if (ld) q <= d;
  end
endmodule

module seg_scan #(
  parameter int DWELL = 50,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_seg0,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic [7:0] i_seg7,
  output logic [7:0] o_seg,
  output logic [7:0] o_an,
  output logic       o_frame
);
  localparam int NUM_DIG = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
  localparam logic [31:0] BLANK_LAST = 32'(BLANK - 1);
  localparam bit          HAS_GAP    = (BLANK > 0);

  logic [1:0]  state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [31:0] cnt, cnt_nx;
  logic [NUM_DIG-1:0][7:0] seg_in, snap;
  logic        load;
  logic [7:0]  show_seg;

  assign seg_in = {i_seg7, i_seg6, i_seg5, i_seg4, i_seg3, i_seg2, i_seg1, i_seg0};
  assign load   = (state == S_LOAD);

  genvar k;
  generate
    for (k = 0; k < NUM_DIG; k++) begin : g_snap
      seg_snap_cell u_cell (
        .clk (clk),
        .rst (rst),
        .ld  (load),
        .d   (seg_in[k]),
        .q   (snap[k])
      );
    end
  endgenerate

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (i_en) state_nx = S_LOAD;
      S_LOAD: begin
        idx_nx   = 3'd0;
        cnt_nx   = 32'd0;
        state_nx = S_SHOW;
      end
      S_SHOW: begin
        if (cnt == DWELL_LAST) begin
          cnt_nx = 32'd0;
          if (HAS_GAP)          state_nx = S_GAP;
          else if (idx == 3'd7) state_nx = S_LOAD;
          else                  idx_nx   = idx + 3'd1;
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      default: begin
        if (cnt == BLANK_LAST) begin
          cnt_nx = 32'd0;
          if (idx == 3'd7) state_nx = S_LOAD;
          else begin
            idx_nx   = idx + 3'd1;
            state_nx = S_SHOW;
          end
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
    endcase
    // Disable discards the frame; re-enable always restarts from LOAD.
    if (!i_en) begin
      state_nx = S_IDLE;
      idx_nx   = 3'd0;
      cnt_nx   = 32'd0;
    end
  end

  // Leaving LOAD the snapshot isn't written yet, so digit 0 comes straight from the inputs.
  assign show_seg = load ? seg_in[0] : snap[idx_nx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= 3'd0;
      cnt     <= 32'd0;
      o_seg   <= 8'hFF;
      o_an    <= 8'hFF;
      o_frame <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      cnt     <= cnt_nx;
      o_frame <= (state_nx == S_LOAD);
      if (state_nx == S_SHOW) begin
        o_an  <= ~(8'd1 << idx_nx);
        o_seg <= show_seg;
      end else begin
        o_an  <= 8'hFF;
        o_seg <= 8'hFF;
      end
    end
  end
endmodule
